// File: rtl/jtframe_romload.sv
// rtl/jtframe_romload.sv - routes a linear ROM download stream into per-region write ports
//
// Splits the byte stream (ioctl_*) into REGIONS regions by address. Each accepted
// byte comes out one clock later on prog_addr/prog_data with a one-hot prog_we
// strobe selecting its region. A small IDLE/LOAD/DONE FSM tracks the download
// window, and statistics (byte_cnt, checksum, overflow) are kept per download.
//
// Optional feature macro: JTFRAME_ROMLOAD_CHECKSUM_EN
//   defined   : checksum = running 16-bit sum of accepted bytes
//   undefined : checksum tied to 0, no adder built
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   downloading          high while the download is in progress
//   ioctl_addr/data/wr   download stream (byte address, byte, write strobe)
//   prog_addr/data/we    region-relative write port, one-hot region strobe
//   busy                 high in LOAD
//   done                 one-cycle pulse (state DONE) at download end
//   overflow             sticky: an in-window byte was outside the mapped range
//   byte_cnt             accepted bytes in the current download (saturating)
//   checksum             sum of accepted bytes, mod 2^16
module jtframe_romload #(
   parameter int                      REGIONS   = 4,
   parameter int                      AW        = 22,
   parameter logic [REGIONS*AW-1:0]   REG_START = {22'hC000, 22'h8000, 22'h4000, 22'h0},
   parameter logic [AW-1:0]           END_ADDR  = 22'h10000
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                downloading,
   input  logic [AW-1:0]       ioctl_addr,
   input  logic [7:0]          ioctl_data,
   input  logic                ioctl_wr,
   output logic [AW-1:0]       prog_addr,
   output logic [7:0]          prog_data,
   output logic [REGIONS-1:0]  prog_we,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [AW:0]         byte_cnt,
   output logic [15:0]         checksum
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t             state, state_nxt;
   logic               dl_q;
   logic               pend;
   logic               rise, fall;
   logic               in_range, accept, oor;
   logic               enter_load;
   logic [REGIONS-1:0] we_sel;
   logic [AW-1:0]      base;

   assign rise     = downloading & ~dl_q;
   assign fall     = ~downloading & dl_q;
   assign in_range = (ioctl_addr >= REG_START[AW-1:0]) && (ioctl_addr < END_ADDR);
   assign accept   = ioctl_wr & downloading & in_range;
   assign oor      = ioctl_wr & downloading & ~in_range;

   // Starts are ascending, so the last matching region is the highest one.
   always_comb begin
      we_sel = '0;
      base   = REG_START[AW-1:0];
      for (int i = 0; i < REGIONS; i++) begin
         if (ioctl_addr >= REG_START[i*AW +: AW]) begin
            we_sel    = '0;
            we_sel[i] = 1'b1;
            base      = REG_START[i*AW +: AW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A rise seen while in DONE is parked in pend so IDLE can still act on it.
   always_comb begin
      state_nxt  = state;
      enter_load = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (rise || pend) begin
               state_nxt  = LOAD;
               enter_load = 1'b1;
            end
         end
         LOAD: begin
            busy = 1'b1;
            if (fall) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dl_q      <= 1'b0;
         pend      <= 1'b0;
         prog_we   <= '0;
         prog_addr <= '0;
         prog_data <= '0;
         overflow  <= 1'b0;
         byte_cnt  <= '0;
      end else begin
         dl_q <= downloading;
         if (enter_load)
            pend <= 1'b0;
         else if (state == DONE && rise)
            pend <= 1'b1;

         prog_we <= accept ? we_sel : '0;
         if (accept) begin
            prog_addr <= ioctl_addr - base;
            prog_data <= ioctl_data;
         end

         // Statistics restart on LOAD entry but still count a byte landing that cycle.
         if (enter_load) begin
            byte_cnt <= {{AW{1'b0}}, accept};
            overflow <= oor;
         end else begin
            if (accept && byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
            if (oor) overflow <= 1'b1;
         end
      end
   end

`ifdef JTFRAME_ROMLOAD_CHECKSUM_EN
   logic [15:0] sum;

   always_ff @(posedge clk) begin
      if (!rst_n)
         sum <= 16'h0;
      else if (enter_load)
         sum <= accept ? {8'h00, ioctl_data} : 16'h0;
      else if (accept)
         sum <= sum + {8'h00, ioctl_data};
   end

   assign checksum = sum;
`else
   assign checksum = 16'h0;
`endif

endmodule

// File: tb/tb_jtframe_romload.sv
// tb/tb_jtframe_romload.sv - self-checking bench for jtframe_romload
module tb_jtframe_romload;

   localparam int AW      = 22;
   localparam int REGIONS = 4;
`ifdef JTFRAME_ROMLOAD_CHECKSUM_EN
   localparam bit CS_ON = 1'b1;
`else
   localparam bit CS_ON = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               downloading = 1'b0;
   logic [AW-1:0]      ioctl_addr = '0;
   logic [7:0]         ioctl_data = '0;
   logic               ioctl_wr = 1'b0;
   logic [AW-1:0]      prog_addr;
   logic [7:0]         prog_data;
   logic [REGIONS-1:0] prog_we;
   logic               busy, done, overflow;
   logic [AW:0]        byte_cnt;
   logic [15:0]        checksum;

   jtframe_romload dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .downloading (downloading),
      .ioctl_addr  (ioctl_addr),
      .ioctl_data  (ioctl_data),
      .ioctl_wr    (ioctl_wr),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_we     (prog_we),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .byte_cnt    (byte_cnt),
      .checksum    (checksum)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int unsigned starts[REGIONS] = '{32'h0, 32'h4000, 32'h8000, 32'hC000};
   int unsigned end_addr = 32'h10000;

   // Reference model: download window and statistics from the address map rules.
   bit          m_prev_dl, m_busy, m_done, m_pend, m_ovf;
   int unsigned m_cnt, m_sum, m_we, m_paddr, m_pdata;

   task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_prev_dl = 0; m_busy = 0; m_done = 0; m_pend = 0; m_ovf = 0;
      m_cnt = 0; m_sum = 0; m_we = 0; m_paddr = 0; m_pdata = 0;
   endtask

   task automatic step(bit rst, bit dl, bit wr, int unsigned addr, int unsigned data);
      bit          rise, fall, inr, acc, oor, enter;
      int unsigned reg_i;
      int unsigned d;
      d           = data & 32'hFF;
      rst_n       = !rst;
      downloading = dl;
      ioctl_wr    = wr;
      ioctl_addr  = addr[AW-1:0];
      ioctl_data  = d[7:0];
      @(posedge clk);
      @(negedge clk);
      if (rst) begin
         model_reset();
      end else begin
         rise  = dl && !m_prev_dl;
         fall  = !dl && m_prev_dl;
         inr   = (addr >= starts[0]) && (addr < end_addr);
         acc   = wr && dl && inr;
         oor   = wr && dl && !inr;
         m_we  = 0;
         reg_i = 0;
         if (acc) begin
            for (int i = 0; i < REGIONS; i++)
               if (addr >= starts[i]) reg_i = i;
            m_we    = 32'd1 << reg_i;
            m_paddr = addr - starts[reg_i];
            m_pdata = d;
         end
         enter = 0;
         if (m_busy) begin
            if (fall) begin m_busy = 0; m_done = 1; end
         end else if (m_done) begin
            m_done = 0;
            if (rise) m_pend = 1;
         end else if (rise || m_pend) begin
            m_busy = 1; m_pend = 0; enter = 1;
         end
         if (enter) begin
            m_cnt = acc ? 1 : 0;
            m_sum = acc ? d : 0;
            m_ovf = oor;
         end else begin
            if (acc && m_cnt < 32'h7FFFFF) m_cnt++;
            if (acc) m_sum = (m_sum + d) & 32'hFFFF;
            if (oor) m_ovf = 1;
         end
         m_prev_dl = dl;
      end
      check_val("prog_we",   32'(prog_we),   m_we);
      check_val("prog_addr", 32'(prog_addr), m_paddr);
      check_val("prog_data", 32'(prog_data), m_pdata);
      check_val("busy",      32'(busy),      32'(m_busy));
      check_val("done",      32'(done),      32'(m_done));
      check_val("overflow",  32'(overflow),  32'(m_ovf));
      check_val("byte_cnt",  32'(byte_cnt),  m_cnt);
      check_val("checksum",  32'(checksum),  CS_ON ? m_sum : 32'h0);
   endtask

   int unsigned a036[4] = '{32'h0000, 32'h4001, 32'h8002, 32'hC003};
   int unsigned d036[4] = '{32'h12, 32'h34, 32'h56, 32'h78};
   int          pulses;

   initial begin
      model_reset();

      // reset state
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check_val("rst_busy", 32'(busy), 32'h0);

      // one byte per region
      step(0, 1, 0, 0, 0);
      check_val("r036_busy", 32'(busy), 32'h1);
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 1, a036[k], d036[k]);
         check_val("r036_we",   32'(prog_we),   32'd1 << k);
         check_val("r036_addr", 32'(prog_addr), 32'(k));
      end
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check_val("r036_done", 32'(done), 32'h1);
      step(0, 0, 0, 0, 0);
      check_val("r036_done_off", 32'(done), 32'h0);
      check_val("r036_cnt", 32'(byte_cnt), 32'd4);
      check_val("r036_sum", 32'(checksum), CS_ON ? 32'h0114 : 32'h0);

      // back-to-back writes
      step(0, 1, 0, 0, 0);
      check_val("r041_cnt_clr", 32'(byte_cnt), 32'd0);
      pulses = 0;
      for (int a = 0; a < 256; a++) begin
         step(0, 1, 1, a, a);
         if (prog_we == 4'b0001) pulses++;
      end
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check_val("r037_pulses", 32'(pulses), 32'd256);
      check_val("r037_cnt", 32'(byte_cnt), 32'd256);
      check_val("r037_sum", 32'(checksum), CS_ON ? 32'h7F80 : 32'h0);

      // out-of-range write
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 32'h0010, 32'hA5);
      step(0, 1, 1, 32'h10000, 32'h5A);
      check_val("r038_we", 32'(prog_we), 32'h0);
      check_val("r038_ovf", 32'(overflow), 32'h1);
      check_val("r038_cnt", 32'(byte_cnt), 32'd1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check_val("r038_ovf_hold", 32'(overflow), 32'h1);

      // write in the falling-edge cycle
      step(0, 1, 0, 0, 0);
      check_val("r041_ovf_clr", 32'(overflow), 32'h0);
      step(0, 1, 1, 32'h0001, 32'h11);
      step(0, 0, 1, 32'h0005, 32'hAA);
      check_val("r039_we", 32'(prog_we), 32'h0);
      check_val("r039_done", 32'(done), 32'h1);
      check_val("r039_cnt", 32'(byte_cnt), 32'd1);
      step(0, 0, 0, 0, 0);

      // reset mid-download
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < 10; k++) step(0, 1, 1, 32'h4000 + k, k + 1);
      check_val("r040_cnt_pre", 32'(byte_cnt), 32'd10);
      step(1, 1, 0, 0, 0);
      check_val("r040_cnt_rst", 32'(byte_cnt), 32'd0);
      check_val("r040_addr_rst", 32'(prog_addr), 32'd0);
      step(0, 1, 0, 0, 0);
      check_val("r040_busy", 32'(busy), 32'h1);
      step(0, 1, 1, 32'h8000, 32'h33);
      check_val("r040_cnt_post", 32'(byte_cnt), 32'd1);

      // rise during DONE is latched
      step(0, 0, 0, 0, 0);
      check_val("r031_done", 32'(done), 32'h1);
      step(0, 1, 0, 0, 0);
      check_val("r031_idle", 32'(busy), 32'h0);
      step(0, 1, 0, 0, 0);
      check_val("r031_load", 32'(busy), 32'h1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // randomized downloads
      for (int n = 0; n < 8; n++) begin
         step(0, 1, 0, 0, 0);
         for (int k = 0; k < int'($urandom_range(60, 20)); k++)
            step(0, 1, $urandom_range(1, 0) != 0, $urandom_range(32'h11000, 0), $urandom);
         step(0, 0, $urandom_range(1, 0) != 0, $urandom_range(32'hFFFF, 0), $urandom);
         for (int k = 0; k < int'($urandom_range(3, 1)); k++)
            step(0, 0, $urandom_range(1, 0) != 0, $urandom_range(32'hFFFF, 0), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
